// File: rtl/aemb_gprf_wrsched.sv
// Write-port scheduler for the 32x32 GPRF: arbitrates ALU/load writebacks through a
// one-entry skid and sequences a zero-clear of every register after reset or on request.
module aemb_gprf_wrsched #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          clr_req,
  input  logic          alu_req,
  input  logic [AW-1:0] alu_rw,
  input  logic [DW-1:0] alu_dat,
  output logic          alu_rdy,
  input  logic          lsu_req,
  input  logic [AW-1:0] lsu_rw,
  input  logic [DW-1:0] lsu_dat,
  output logic          w_wre,
  output logic [AW-1:0] w_rw,
  output logic [DW-1:0] w_dat,
  output logic          busy,
  output logic          lsu_err
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          skid_v_q, skid_v_d;
  logic [AW-1:0] skid_rw_q, skid_rw_d;
  logic [DW-1:0] skid_dat_q, skid_dat_d;
  logic          clr_pend_q, clr_pend_d;
  logic          lsu_err_q, lsu_err_d;
  logic          w_wre_q, w_wre_d;
  logic [AW-1:0] w_rw_q, w_rw_d;
  logic [DW-1:0] w_dat_q, w_dat_d;

  logic          alu_rdy_s;
  logic          alu_acc_s;
  logic          wr_v_s;
  logic [AW-1:0] wr_rw_s;
  logic [DW-1:0] wr_dat_s;

  assign alu_rdy_s = (state_q == ST_RUN) & ~skid_v_q & gena;
  assign alu_acc_s = alu_req & alu_rdy_s;

  // Next-state, skid and write-port computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    skid_v_d   = skid_v_q;
    skid_rw_d  = skid_rw_q;
    skid_dat_d = skid_dat_q;
    clr_pend_d = clr_pend_q;
    lsu_err_d  = lsu_err_q;
    w_wre_d    = 1'b0;
    w_rw_d     = w_rw_q;
    w_dat_d    = w_dat_q;
    wr_v_s     = 1'b0;
    wr_rw_s    = {AW{1'b0}};
    wr_dat_s   = {DW{1'b0}};
    if (gena) begin
      case (state_q)
        ST_CLEAR: begin
          w_wre_d = 1'b1;
          w_rw_d  = cnt_q;
          w_dat_d = {DW{1'b0}};
          cnt_d   = cnt_q + AW'(1);
          if (cnt_q == {AW{1'b1}}) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_CLEAR;
          end
          if (lsu_req) begin
            lsu_err_d = 1'b1;
          end else begin
            lsu_err_d = lsu_err_q;
          end
        end
        ST_RUN: begin
          // Load cannot stall, so an ALU result accepted alongside it parks in the skid
          if (lsu_req) begin
            wr_v_s   = 1'b1;
            wr_rw_s  = lsu_rw;
            wr_dat_s = lsu_dat;
            if (alu_acc_s) begin
              skid_v_d   = 1'b1;
              skid_rw_d  = alu_rw;
              skid_dat_d = alu_dat;
            end else begin
              skid_v_d   = skid_v_q;
            end
          end else if (skid_v_q) begin
            wr_v_s   = 1'b1;
            wr_rw_s  = skid_rw_q;
            wr_dat_s = skid_dat_q;
            skid_v_d = 1'b0;
          end else if (alu_acc_s) begin
            wr_v_s   = 1'b1;
            wr_rw_s  = alu_rw;
            wr_dat_s = alu_dat;
          end else begin
            wr_v_s   = 1'b0;
          end
          if (wr_v_s) begin
            w_wre_d = (wr_rw_s != {AW{1'b0}});
            w_rw_d  = wr_rw_s;
            w_dat_d = wr_dat_s;
          end else begin
            w_wre_d = 1'b0;
          end
          // A clear waits until the skid is empty so no accepted write is lost
          if ((clr_req | clr_pend_q) & ~skid_v_d) begin
            state_d    = ST_CLEAR;
            cnt_d      = {AW{1'b0}};
            clr_pend_d = 1'b0;
          end else begin
            clr_pend_d = clr_req | clr_pend_q;
          end
        end
        default: begin
          state_d = ST_CLEAR;
          cnt_d   = {AW{1'b0}};
        end
      endcase
    end else begin
      w_wre_d = 1'b0;
    end
  end

  // State and registered write port
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= {AW{1'b0}};
      skid_v_q   <= 1'b0;
      skid_rw_q  <= {AW{1'b0}};
      skid_dat_q <= {DW{1'b0}};
      clr_pend_q <= 1'b0;
      lsu_err_q  <= 1'b0;
      w_wre_q    <= 1'b0;
      w_rw_q     <= {AW{1'b0}};
      w_dat_q    <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      skid_v_q   <= skid_v_d;
      skid_rw_q  <= skid_rw_d;
      skid_dat_q <= skid_dat_d;
      clr_pend_q <= clr_pend_d;
      lsu_err_q  <= lsu_err_d;
      w_wre_q    <= w_wre_d;
      w_rw_q     <= w_rw_d;
      w_dat_q    <= w_dat_d;
    end
  end

  assign alu_rdy = alu_rdy_s;
  assign busy    = (state_q == ST_CLEAR);
  assign lsu_err = lsu_err_q;
  assign w_wre   = w_wre_q;
  assign w_rw    = w_rw_q;
  assign w_dat   = w_dat_q;

endmodule

// File: tb/tb_aemb_gprf_wrsched.sv
// Directed bench for aemb_gprf_wrsched: clear sequence, arbitration, skid, r0 rule,
// gena freeze and reset behaviour, with hand-computed expectations.
module tb_aemb_gprf_wrsched;

  logic        gclk;
  logic        grst;
  logic        gena;
  logic        clr_req;
  logic        alu_req;
  logic [4:0]  alu_rw;
  logic [31:0] alu_dat;
  logic        alu_rdy;
  logic        lsu_req;
  logic [4:0]  lsu_rw;
  logic [31:0] lsu_dat;
  logic        w_wre;
  logic [4:0]  w_rw;
  logic [31:0] w_dat;
  logic        busy;
  logic        lsu_err;

  int total_cnt = 0;
  int bad_cnt   = 0;

  aemb_gprf_wrsched #(.AW(5), .DW(32)) dut (
    .gclk(gclk), .grst(grst), .gena(gena), .clr_req(clr_req),
    .alu_req(alu_req), .alu_rw(alu_rw), .alu_dat(alu_dat), .alu_rdy(alu_rdy),
    .lsu_req(lsu_req), .lsu_rw(lsu_rw), .lsu_dat(lsu_dat),
    .w_wre(w_wre), .w_rw(w_rw), .w_dat(w_dat), .busy(busy), .lsu_err(lsu_err)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic chk_w(input string tag, input logic wre, input logic [4:0] rw, input logic [31:0] dat);
    chk({tag, ".wre"}, {31'd0, w_wre}, {31'd0, wre});
    chk({tag, ".rw"},  {27'd0, w_rw},  {27'd0, rw});
    chk({tag, ".dat"}, w_dat, dat);
  endtask

  initial begin
    grst = 1'b0; gena = 1'b1; clr_req = 1'b0;
    alu_req = 1'b0; alu_rw = 5'd0; alu_dat = 32'd0;
    lsu_req = 1'b0; lsu_rw = 5'd0; lsu_dat = 32'd0;
    #12;
    chk("rst.busy", {31'd0, busy}, 32'd1);
    chk("rst.alu_rdy", {31'd0, alu_rdy}, 32'd0);
    chk("rst.lsu_err", {31'd0, lsu_err}, 32'd0);
    chk_w("rst", 1'b0, 5'd0, 32'd0);

    // 1: clear sequence after reset release
    @(negedge gclk) grst = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      chk_w("clr1", 1'b1, 5'(k), 32'd0);
      chk("clr1.busy", {31'd0, busy}, (k == 31) ? 32'd0 : 32'd1);
    end
    chk("clr1.alu_rdy", {31'd0, alu_rdy}, 32'd1);

    // 2: plain ALU write
    alu_req = 1'b1; alu_rw = 5'd5; alu_dat = 32'h1234;
    tick();
    alu_req = 1'b0;
    chk_w("alu5", 1'b1, 5'd5, 32'h1234);

    // 3: same-destination conflict, load first then ALU
    alu_req = 1'b1; alu_rw = 5'd3; alu_dat = 32'hA;
    lsu_req = 1'b1; lsu_rw = 5'd3; lsu_dat = 32'hB;
    tick();
    alu_req = 1'b0; lsu_req = 1'b0;
    chk_w("conf.ld", 1'b1, 5'd3, 32'hB);
    chk("conf.rdy", {31'd0, alu_rdy}, 32'd0);
    tick();
    chk_w("conf.alu", 1'b1, 5'd3, 32'hA);
    chk("conf.rdy2", {31'd0, alu_rdy}, 32'd1);

    // 4: skid held behind three loads
    alu_req = 1'b1; alu_rw = 5'd7; alu_dat = 32'h77;
    for (int k = 0; k < 3; k++) begin
      lsu_req = 1'b1; lsu_rw = 5'(8 + k); lsu_dat = 32'h80 + 32'(k);
      tick();
      if (k == 0) alu_rw = 5'd9;
      chk_w("skid.ld", 1'b1, 5'(8 + k), 32'h80 + 32'(k));
      chk("skid.rdy", {31'd0, alu_rdy}, 32'd0);
    end
    lsu_req = 1'b0; alu_req = 1'b0;
    tick();
    chk_w("skid.drain", 1'b1, 5'd7, 32'h77);
    chk("skid.rdy2", {31'd0, alu_rdy}, 32'd1);

    // 5: r0 write suppressed but consumed
    alu_req = 1'b1; alu_rw = 5'd0; alu_dat = 32'h55;
    chk("r0.rdy", {31'd0, alu_rdy}, 32'd1);
    tick();
    alu_req = 1'b0;
    chk("r0.wre", {31'd0, w_wre}, 32'd0);
    tick();
    chk("r0.gone", {31'd0, w_wre}, 32'd0);
    chk("r0.rdy2", {31'd0, alu_rdy}, 32'd1);

    // soft clear with a dropped load and a gena freeze at counter 10
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("sclr.busy", {31'd0, busy}, 32'd1);
    chk("sclr.wre", {31'd0, w_wre}, 32'd0);
    chk("sclr.rdy", {31'd0, alu_rdy}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      if (k == 3) begin
        lsu_req = 1'b1; lsu_rw = 5'd4; lsu_dat = 32'h99;
      end
      if (k == 10) begin
        gena = 1'b0;
        for (int j = 0; j < 4; j++) begin
          tick();
          chk("frz.wre", {31'd0, w_wre}, 32'd0);
          chk("frz.busy", {31'd0, busy}, 32'd1);
        end
        gena = 1'b1;
      end
      tick();
      lsu_req = 1'b0;
      chk_w("clr2", 1'b1, 5'(k), 32'd0);
      if (k == 3) chk("lerr.set", {31'd0, lsu_err}, 32'd1);
    end
    chk("clr2.busy", {31'd0, busy}, 32'd0);
    chk("lerr.sticky", {31'd0, lsu_err}, 32'd1);

    // write in RUN, then async reset restarts the clear at 0
    alu_req = 1'b1; alu_rw = 5'd6; alu_dat = 32'h66;
    tick();
    alu_req = 1'b0;
    chk_w("alu6", 1'b1, 5'd6, 32'h66);
    @(negedge gclk) grst = 1'b0;
    #1;
    chk("rst2.busy", {31'd0, busy}, 32'd1);
    chk("rst2.wre", {31'd0, w_wre}, 32'd0);
    chk("rst2.lsu_err", {31'd0, lsu_err}, 32'd0);
    chk("rst2.rdy", {31'd0, alu_rdy}, 32'd0);
    @(negedge gclk) grst = 1'b1;
    tick();
    chk_w("clr3.0", 1'b1, 5'd0, 32'd0);
    tick();
    chk_w("clr3.1", 1'b1, 5'd1, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
